// File: rtl/sccb_arbiter.sv
// Two-requester arbiter in front of a single SCCB master: picks a winner, latches
// its transaction fields, launches the master, and returns done/err to the owner.
module sccb_arbiter #(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter bit RR_EN          = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] devaddr0,
    input  logic [7:0] devaddr1,
    input  logic [7:0] regaddr0,
    input  logic [7:0] regaddr1,
    input  logic [7:0] wrdata0,
    input  logic [7:0] wrdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rddata,
    output logic       m_en,
    output logic [7:0] m_devaddr,
    output logic [7:0] m_regaddr,
    output logic [7:0] m_wrdata,
    input  logic       m_done,
    input  logic [7:0] m_rddata,
    output logic       busy
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;   // 0 = requester 0, 1 = requester 1
    logic          last_q, last_d;
    logic          m_en_q, m_en_d;
    logic          done0_q, done0_d, done1_q, done1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [7:0]    dev_q, dev_d, reg_q, reg_d, wd_q, wd_d, rd_q, rd_d;
    logic          win;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        m_en_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        // With a single request the requester itself wins; contention uses the pointer.
        win     = (req0 && req1) ? (RR_EN ? ~last_q : 1'b0) : req1;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d = win;
                    dev_d   = win ? devaddr1 : devaddr0;
                    reg_d   = win ? regaddr1 : regaddr0;
                    wd_d    = win ? wrdata1  : wrdata0;
                    state_d = S_START;
                end
            end
            S_START: begin
                m_en_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_done) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    if (dev_q[0]) begin
                        rd_d = m_rddata;
                    end
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_MAX) begin
                    err0_d  = ~owner_q;
                    err1_d  = owner_q;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RELEASE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            m_en_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            dev_q   <= 8'h00;
            reg_q   <= 8'h00;
            wd_q    <= 8'h00;
            rd_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            m_en_q  <= m_en_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
        end
    end

    // Grant spans START through RELEASE, so it follows directly from state and owner.
    assign busy      = (state_q != S_IDLE);
    assign gnt0      = busy && !owner_q;
    assign gnt1      = busy && owner_q;
    assign m_en      = m_en_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign m_devaddr = dev_q;
    assign m_regaddr = reg_q;
    assign m_wrdata  = wd_q;
    assign rddata    = rd_q;
endmodule

// File: doc/sccb_arbiter.md
SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000: maximum cycles in WAIT before a transaction is abandoned (≥2).
REQ-002 SHALL have parameter RR_EN, default 1: 1 selects round-robin arbitration, 0 selects fixed priority to requester 0.
REQ-003 SHALL have port clk  input  1: the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have ports req0/req1  input  1 each: the requester holds the line high until it sees its done or err pulse.
REQ-006 SHALL have ports devaddr0/devaddr1  input  8 each: SCCB device address; bit0 gives direction, 1 = read.
REQ-007 SHALL have ports regaddr0/regaddr1, wrdata0/wrdata1  input  8 each: register address and write data.
REQ-008 SHALL have ports gnt0/gnt1  output  1 each: high while that requester owns the master.
REQ-009 SHALL have ports done0/done1, err0/err1  output  1 each: one-cycle completion and timeout pulses.
REQ-010 SHALL have port rddata  output  8: data captured on the last successful completion.
REQ-011 SHALL have ports m_en  output  1, and m_devaddr/m_regaddr/m_wrdata  output  8: start pulse and fields sent to the SCCB master.
REQ-012 SHALL have ports m_done  input  1 and m_rddata  input  8: the master's completion pulse and read data.
REQ-013 SHALL have port busy  output  1: high in every state other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, START, WAIT and RELEASE.
REQ-015 In IDLE with any req high, SHALL select a winner, latch its devaddr/regaddr/wrdata into the m_* registers, set its gnt and enter START on the same edge.
REQ-016 Arbitration when both req are high SHALL follow these rules:
  - RR_EN=1: grant the requester not served last.
  - RR_EN=0: grant req0.
  - The last-served pointer resets to 1, so req0 wins first.
REQ-017 START SHALL assert m_en for exactly one cycle, then enter WAIT; the first m_en is 2 cycles after req is sampled high.
REQ-018 m_* fields SHALL stay stable from START until RELEASE exits, regardless of requester inputs.
REQ-019 WAIT behaviour:
  - The counter clears on entry and increments each cycle.
  - On m_done: capture m_rddata into rddata if latched devaddr[0]=1, pulse done of the granted requester, enter RELEASE.
  - If the counter reaches TIMEOUT_CYCLES-1 without m_done: pulse err of the granted requester, leave rddata unchanged, enter RELEASE.
  - If m_done and timeout fall in the same cycle, m_done wins; no err pulse.
REQ-020 RELEASE SHALL last one cycle:
  - gnt deasserts on exit.
  - The last-served pointer updates.
  - The next state is IDLE, giving at least one idle cycle between transactions.
REQ-021 gnt0 and gnt1 SHALL never be high together, and at most one of done/err SHALL pulse per transaction.
REQ-022 m_done SHALL be ignored outside WAIT.
REQ-023 If the granted requester drops req mid-transaction, the transaction SHALL still complete normally and its done/err SHALL still pulse.
REQ-024 A requester that keeps req high after its done SHALL be treated as a new request in IDLE.
REQ-025 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide and SHALL NOT wrap within one transaction.

Reset
REQ-026 On rst_n low, asynchronously and regardless of state:
  - state = IDLE.
  - gnt0/1, done0/1, err0/1, m_en, busy = 0.
  - m_devaddr, m_regaddr, m_wrdata, rddata = 0x00.
  - Timeout counter = 0; pointer = 1.
REQ-027 Reset asserted mid-transaction SHALL abort it with no done/err pulse; the first grant after release follows REQ-015/016.

Verification
REQ-028 Single write: req0 with dev=0x42, reg=0x12, wdat=0x80; m_done 100 cycles after m_en -> m_en 2 cycles after req, fields match, done0 one pulse, rddata stays 0x00.
REQ-029 Read: req1 with dev=0x43; m_rddata=0xA5 with m_done -> done1 pulse and rddata=0xA5.
REQ-030 Contention, RR_EN=1, both req held high -> grants alternate 0,1,0,1 across four transactions, never overlap, with one idle cycle between them.
REQ-031 Timeout, TIMEOUT_CYCLES=50, m_done never asserted -> err0 pulses 50 cycles after WAIT entry, no done0, arbiter returns to IDLE.
REQ-032 Edge cases:
  - m_done on the timeout cycle -> done only.
  - rst_n low during WAIT -> all outputs 0 immediately, no pulse.
  - Spurious m_done in IDLE -> ignored.
